// File: rtl/phy_rx_serial_paralelo.sv
// phy_rx_serial_paralelo: comma-aligned 1-bit MSB-first to byte receiver.
// Latency: a byte lands on data_out at the edge sampling its LSB; byte_strobe is high the following cycle.
// Backpressure: none; one byte slot every 8 bit clocks, the downstream lane demux must keep pace.
// Ports: clk serial bit clock; reset_L async active-low reset; data_in serial bit;
//   active link locked; data_out last complete byte; valid_out byte is payload (not comma);
//   byte_strobe one-cycle update pulse; rx_byte_cnt saturating payload-byte count
//   (present only when RX_BYTE_COUNT_EN is defined).
module phy_rx_serial_paralelo #(
  parameter logic [7:0] BC_CHAR     = 8'hBC,
  parameter int         BC_REQUIRED = 4      // legal range 1..15
) (
  input  logic        clk,
  input  logic        reset_L,
  input  logic        data_in,
  output logic        active,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        byte_strobe
`ifdef RX_BYTE_COUNT_EN
  ,
  output logic [15:0] rx_byte_cnt
`endif
);

  localparam logic [1:0] SEARCH  = 2'd0;
  localparam logic [1:0] ALIGNED = 2'd1;
  localparam logic [1:0] ACTIVE  = 2'd2;

  localparam logic [3:0] BC_REQ = 4'(BC_REQUIRED);

  logic [1:0] state;
  logic [7:0] sr;
  logic [2:0] bit_cnt;
  logic [3:0] bc_cnt;

  logic [7:0] nxt;
  logic       byte_done;
  logic       is_comma;

  // Window including the bit being sampled this edge.
  assign nxt       = {sr[6:0], data_in};
  assign byte_done = (bit_cnt == 3'd7);
  assign is_comma  = (nxt == BC_CHAR);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state       <= SEARCH;
      sr          <= 8'h00;
      bit_cnt     <= 3'd0;
      bc_cnt      <= 4'd0;
      active      <= 1'b0;
      data_out    <= 8'h00;
      valid_out   <= 1'b0;
      byte_strobe <= 1'b0;
    end else begin
      sr          <= nxt;
      byte_strobe <= 1'b0;
      case (state)
        SEARCH: begin
          // Hunt bit-by-bit; a match at any offset becomes the candidate alignment.
          bit_cnt <= 3'd0;
          if (is_comma) begin
            bc_cnt <= 4'd1;
            if (BC_REQ == 4'd1) begin
              state  <= ACTIVE;
              active <= 1'b1;
            end else begin
              state <= ALIGNED;
            end
          end
        end
        ALIGNED: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (byte_done) begin
            if (is_comma) begin
              bc_cnt <= bc_cnt + 4'd1;
              if ((bc_cnt + 4'd1) == BC_REQ) begin
                state  <= ACTIVE;
                active <= 1'b1;
              end
            end else begin
              // False alignment: drop it and resume the bitwise hunt.
              state  <= SEARCH;
              bc_cnt <= 4'd0;
            end
          end
        end
        ACTIVE: begin
          // No loss-of-lock detection; only reset leaves this state.
          bit_cnt <= bit_cnt + 3'd1;
          if (byte_done) begin
            data_out    <= nxt;
            valid_out   <= !is_comma;
            byte_strobe <= 1'b1;
          end
        end
        default: begin
          state   <= SEARCH;
          bit_cnt <= 3'd0;
          bc_cnt  <= 4'd0;
        end
      endcase
    end
  end

`ifdef RX_BYTE_COUNT_EN
  // Payload bytes only; sticks at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rx_byte_cnt <= 16'h0000;
    end else if ((state == ACTIVE) && byte_done && !is_comma &&
                 (rx_byte_cnt != 16'hFFFF)) begin
      rx_byte_cnt <= rx_byte_cnt + 16'd1;
    end
  end
`endif

endmodule
